// File: rtl/alu181_pkg.sv
// Shared constants and the operand-stage entry layout for the 74181-style ALU datapath.
// The entry struct here is the 74181-width form; the top stage declares the same layout at its own WIDTH.
package alu181_pkg;

    localparam int ALU_W = 4;

    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_XOR = 4'b0110;  // with m = 1

    typedef struct packed {
        logic [ALU_W-1:0] gb;
        logic [ALU_W-1:0] pb;
        logic [ALU_W-1:0] c;
        logic             m;
        logic             cn4_n;
        logic             g_n;
        logic             p_n;
    } alu181_entry_t;

endpackage

// File: rtl/alu181_gp_calc.sv
// First-level 74181 terms: per-bit generate/propagate bars, ripple lookahead carries and group P/G.
module alu181_gp_calc
    import alu181_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             cn_n,
    output logic [WIDTH-1:0] gb,
    output logic [WIDTH-1:0] pb,
    output logic [WIDTH-1:0] c,
    output logic             cn4_n,
    output logic             g_n,
    output logic             p_n
);

    logic [WIDTH:0] carry;
    logic [WIDTH:0] grp;

    assign carry[0] = ~cn_n;
    // Group generate is the same carry recurrence seeded with zero carry-in.
    assign grp[0]   = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : gen_bit
            assign pb[gi]        = ~(a[gi] | (b[gi] & s[0]) | (~b[gi] & s[1]));
            assign gb[gi]        = ~((a[gi] & ~b[gi] & s[2]) | (a[gi] & b[gi] & s[3]));
            assign carry[gi + 1] = ~gb[gi] | (~pb[gi] & carry[gi]);
            assign grp[gi + 1]   = ~gb[gi] | (~pb[gi] & grp[gi]);
        end
    endgenerate

    assign c     = carry[WIDTH-1:0];
    assign cn4_n = ~carry[WIDTH];
    assign g_n   = ~grp[WIDTH];
    assign p_n   = ~(&(~pb));

endmodule

// File: rtl/alu181_operand_stage.sv
// Operand stage: computes 74181 first-level terms on accept and buffers them in a 2-entry skid FIFO.
module alu181_operand_stage
    import alu181_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gb,
    output logic [WIDTH-1:0] pb,
    output logic [WIDTH-1:0] c,
    output logic             m_q,
    output logic             cn4_n,
    output logic             g_n,
    output logic             p_n
);

    typedef struct packed {
        logic [WIDTH-1:0] gb;
        logic [WIDTH-1:0] pb;
        logic [WIDTH-1:0] c;
        logic             m;
        logic             cn4_n;
        logic             g_n;
        logic             p_n;
    } entry_t;

    logic [WIDTH-1:0] calc_gb, calc_pb, calc_c;
    logic             calc_cn4_n, calc_g_n, calc_p_n;
    entry_t           new_entry;
    entry_t           head;

    logic [1:0] count_reg, count_next;
    logic       wr_ptr_reg, rd_ptr_reg;
    logic       push, pop;

    alu181_gp_calc #(.WIDTH(WIDTH)) u_gp_calc (
        .a     (a),
        .b     (b),
        .s     (s),
        .cn_n  (cn_n),
        .gb    (calc_gb),
        .pb    (calc_pb),
        .c     (calc_c),
        .cn4_n (calc_cn4_n),
        .g_n   (calc_g_n),
        .p_n   (calc_p_n)
    );

    always_comb begin
        new_entry       = '0;
        new_entry.gb    = calc_gb;
        new_entry.pb    = calc_pb;
        new_entry.c     = calc_c;
        new_entry.m     = m;
        new_entry.cn4_n = calc_cn4_n;
        new_entry.g_n   = calc_g_n;
        new_entry.p_n   = calc_p_n;
    end

    // in_ready depends on occupancy only, so out_ready never reaches it combinationally.
    assign in_ready  = (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_entry
            entry_t entry_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    entry_reg <= '0;
                else if (push && (wr_ptr_reg == 1'(gi)))
                    entry_reg <= new_entry;
            end
        end
    endgenerate

    assign head  = rd_ptr_reg ? gen_entry[1].entry_reg : gen_entry[0].entry_reg;

    assign gb    = head.gb;
    assign pb    = head.pb;
    assign c     = head.c;
    assign m_q   = head.m;
    assign cn4_n = head.cn4_n;
    assign g_n   = head.g_n;
    assign p_n   = head.p_n;

endmodule

// File: doc/alu181_operand_stage.md
Name: alu181_operand_stage

Overview:
- Upstream pipeline stage of the 74181-style ALU datapath.
- Accepts an operation (A, B, S, M, Cn) over a valid/ready handshake and computes the first-level per-bit terms gb/pb, the internal lookahead carries C, and the group P/G outputs.
- Buffers results in a 2-entry skid FIFO and presents them to the sum/compare stage (F, AeqB), which consumes gb, pb, C, M.
- Decouples the final stage from operand-source backpressure while sustaining 1 op/cycle.

Parameters:
- WIDTH, 4, data width in bits; must be ≥1, and 4 is the 74181 slice width.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operand word valid
- in_ready  out  1  stage can accept this cycle
- a  in  WIDTH  operand A (active-high data)
- b  in  WIDTH  operand B
- s  in  4  function select S3..S0
- m  in  1  mode: 1 = logic, 0 = arithmetic
- cn_n  in  1  carry-in, active-low (1 = no carry)
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts
- gb  out  WIDTH  generate-bar terms
- pb  out  WIDTH  propagate-bar terms
- c  out  WIDTH  active-high carry into each bit; c[0] = ~cn_n
- m_q  out  1  registered mode, travels with the word
- cn4_n  out  1  carry-out of MSB, active-low
- g_n  out  1  group generate-bar
- p_n  out  1  group propagate-bar

Behaviour:
- Per bit i:
  - pb[i] = ~(a[i] | (b[i]&s[0]) | (~b[i]&s[1]))
  - gb[i] = ~((a[i]&~b[i]&s[2]) | (a[i]&b[i]&s[3]))
- Carry terms: G[i] = ~gb[i], P[i] = ~pb[i]; c[0] = ~cn_n; c[i+1] = G[i] | (P[i]&c[i]).
- Carry-out: cn4_n = ~c[WIDTH].
- Group outputs:
  - p_n = ~(&P)
  - g_n = ~(G[W-1] | P[W-1]G[W-2] | … | P[W-1..1]G[0])
- Carries are computed irrespective of m; the downstream stage masks them with M.
- All of the above are computed combinationally on the input, then stored as one FIFO entry: {gb, pb, c, m, cn4_n, g_n, p_n}.
- FIFO depth 2, occupancy count 0..2.
  - in_ready = (count != 2). It is a function of count only; there is no combinational path from out_ready.
  - out_valid = (count != 0).
  - Output fields always show the head entry; they are stable while out_valid && !out_ready.
- Push when in_valid && in_ready; pop when out_valid && out_ready.
  - count 0: push only → count 1. Data is visible the next cycle (latency 1).
  - count 1: push and pop together → count stays 1 and the new word becomes head. Throughput is 1/cycle.
  - count 2: push is impossible. A pop makes the second entry head, count 1, and in_ready is high the next cycle.
- Order is strictly FIFO; no word is dropped or duplicated.
- Reset (rst_n low, asynchronous):
  - count 0, out_valid 0, in_ready 1.
  - All entry registers 0, so gb, pb, c, m_q = 0 and cn4_n, g_n, p_n = 0.
  - A reset during operation discards buffered words; no partial word is emitted after release.
- Inputs are ignored while in_valid = 0. Data values are don't-care when in_valid = 0.

Decomposition:
- Package alu181_pkg holds:
  - ALU_W = 4
  - S_ADD = 4'b1001, S_SUB = 4'b0110, S_XOR = 4'b0110 (with M=1)
  - the entry struct typedef alu181_entry_t {gb, pb, c, m, cn4_n, g_n, p_n}.
- Sub-module alu181_gp_calc: pure combinational generation of gb/pb/c/group terms from a, b, s, cn_n.
- The top level holds the handshake and the 2-entry FIFO only.

Test Plan:
- Reset: hold rst_n=0 3 cycles with in_valid=1 → out_valid=0, in_ready=1, all outputs 0; release → first accepted word appears 1 cycle after acceptance.
- Add: a=5, b=3, s=1001, m=0, cn_n=1 → gb=4'hE, pb=4'h8, c=4'b1110, cn4_n=1, m_q=0; downstream F=8.
- Subtract: a=3, b=5, s=0110, m=0, cn_n=0 → c[0]=1, cn4_n=1 (borrow), downstream F=4'hE.
- Logic XOR: a=4'hA, b=4'h6, s=0110, m=1, cn_n=1 → pb=4'h4, gb=4'h7, c=0, cn4_n=0, m_q=1; downstream F=4'hC.
- Backpressure: out_ready=0, offer 3 words → in_ready drops after 2, third held; raise out_ready → 3 results in order, no loss.
- Streaming and async reset: out_ready=1, in_valid=1 for 8 cycles → 8 results on consecutive cycles. Then fill to count 2 and pulse rst_n low mid-cycle → out_valid=0 immediately, FIFO empty after release.
